// File: rtl/slot_round_controller.sv
// One play round of the three-reel slot: button sync, start/stop sequencing,
// match evaluation, saturating credits and win-buzzer timing.
module slot_round_controller #(
   parameter int SYM_W          = 4,
   parameter int CREDIT_W       = 8,
   parameter int INIT_CREDITS   = 10,
   parameter int PAYOUT         = 5,
   parameter int MIN_SPIN_TICKS = 8,
   parameter int STAGGER_TICKS  = 4,
   parameter int WIN_TICKS      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick,
   input  logic                start_stop,
   input  logic [SYM_W-1:0]    reel0_sym,
   input  logic [SYM_W-1:0]    reel1_sym,
   input  logic [SYM_W-1:0]    reel2_sym,
   output logic [2:0]          reel_run,
   output logic                reel_clear,
   output logic                win_flag,
   output logic                buzzer_en,
   output logic [CREDIT_W-1:0] credits,
   output logic [2:0]          state_o
);

   localparam int TMAX0  = (MIN_SPIN_TICKS > STAGGER_TICKS) ? MIN_SPIN_TICKS : STAGGER_TICKS;
   localparam int TMAX   = (TMAX0 > WIN_TICKS) ? TMAX0 : WIN_TICKS;
   localparam int TCNT_W = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SPIN  = 3'd1,
      STOP1 = 3'd2,
      STOP2 = 3'd3,
      EVAL  = 3'd4,
      WIN   = 3'd5
   } state_t;

   state_t              state, state_n;
   logic [TCNT_W-1:0]   tcnt;
   logic [2:0]          run_n;
   logic                win;
   logic                start_round;
   logic [CREDIT_W:0]   credit_sum;
   logic [CREDIT_W-1:0] credit_win;

   // Button path: 2-flop sync, edge detect, registered press.
   // arm only sets once the sync chain holds real samples that show the button
   // released, so a button held through reset cannot start a round.
   logic sync0, sync1, sync_prev, fill0, fill1, arm, press;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync0     <= 1'b0;
         sync1     <= 1'b0;
         sync_prev <= 1'b0;
         fill0     <= 1'b0;
         fill1     <= 1'b0;
         arm       <= 1'b0;
         press     <= 1'b0;
      end else begin
         sync0     <= start_stop;
         sync1     <= sync0;
         sync_prev <= sync1;
         fill0     <= 1'b1;
         fill1     <= fill0;
         if (fill1 && !sync1) arm <= 1'b1;
         press     <= arm & sync1 & ~sync_prev;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      run_n   = 3'b000;
      win     = (reel0_sym == reel1_sym) && (reel1_sym == reel2_sym);
      case (state)
         IDLE:  if (press && credits != '0) state_n = SPIN;
         SPIN:  if (press && tcnt >= TCNT_W'(MIN_SPIN_TICKS)) state_n = STOP1;
         STOP1: if (tcnt >= TCNT_W'(STAGGER_TICKS)) state_n = STOP2;
         STOP2: if (tcnt >= TCNT_W'(STAGGER_TICKS)) state_n = EVAL;
         EVAL:  state_n = win ? WIN : IDLE;
         WIN:   if (tcnt >= TCNT_W'(WIN_TICKS)) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      case (state_n)
         SPIN:    run_n = 3'b111;
         STOP1:   run_n = 3'b110;
         STOP2:   run_n = 3'b100;
         default: run_n = 3'b000;
      endcase
   end

   assign start_round = (state == IDLE) && (state_n == SPIN);
   assign credit_sum  = {1'b0, credits} + (CREDIT_W+1)'(PAYOUT);
   assign credit_win  = credit_sum[CREDIT_W] ? '1 : credit_sum[CREDIT_W-1:0];

   // Outputs are registered from the next state so they change with state_o.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt       <= '0;
         credits    <= CREDIT_W'(INIT_CREDITS);
         win_flag   <= 1'b0;
         reel_run   <= 3'b000;
         reel_clear <= 1'b0;
         buzzer_en  <= 1'b0;
      end else begin
         if (state_n != state)          tcnt <= '0;
         else if (tick && tcnt != '1)   tcnt <= tcnt + 1'b1;
         reel_clear <= start_round;
         reel_run   <= run_n;
         buzzer_en  <= (state_n == WIN);
         if (start_round) begin
            credits  <= credits - 1'b1;
            win_flag <= 1'b0;
         end else if (state == EVAL) begin
            win_flag <= win;
            if (win) credits <= credit_win;
         end
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_slot_round_controller.sv
// Randomized round-level bench: expected state, reel enables and credits come
// from the play rules, with a second narrow-credit instance for saturation.
module tb_slot_round_controller;

   logic       clk = 1'b0;
   logic       rst, tick, start_stop;
   logic [3:0] sa, sb, sc;
   logic [2:0] run_a, run_b, st_a, st_b;
   logic       clr_a, clr_b, wf_a, wf_b, bz_a, bz_b;
   logic [7:0] cr_a;
   logic [3:0] cr_b;

   int  n_chk = 0, n_err = 0;
   int  exp_c, exp_c2;
   bit  chk2;

   always #5 clk = ~clk;

   slot_round_controller dut_a (
      .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
      .reel0_sym(sa), .reel1_sym(sb), .reel2_sym(sc),
      .reel_run(run_a), .reel_clear(clr_a), .win_flag(wf_a), .buzzer_en(bz_a),
      .credits(cr_a), .state_o(st_a));

   slot_round_controller #(.CREDIT_W(4), .INIT_CREDITS(13)) dut_b (
      .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
      .reel0_sym(sa), .reel1_sym(sb), .reel2_sym(sc),
      .reel_run(run_b), .reel_clear(clr_b), .win_flag(wf_b), .buzzer_en(bz_b),
      .credits(cr_b), .state_o(st_b));

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_tick(input int n);
      repeat (n) begin
         tick = 1'b1; step(1);
         tick = 1'b0; step(1);
      end
   endtask

   // mode 0: plain stop press after >= 8 ticks; 1: early press at tcnt=5 first;
   // 2: press coincident with the tick that takes tcnt 7->8 (rejected) first.
   task automatic play_round(input int a, input int b, input int c, input int mode);
      bit w;
      w = (a == b) && (b == c);
      chk("idle_before", st_a, 0);
      sa = 4'(a); sb = 4'(b); sc = 4'(c);
      start_stop = 1'b1; step(4);
      chk("spin_state", st_a, 1);
      chk("spin_run", run_a, 7);
      chk("clear_pulse", clr_a, 1);
      chk("credit_dec", cr_a, exp_c - 1);
      chk("wf_cleared", wf_a, 0);
      exp_c--;
      if (chk2) begin
         chk("credit_dec_b", cr_b, exp_c2 - 1);
         exp_c2--;
      end
      step(1);
      chk("clear_end", clr_a, 0);
      start_stop = 1'b0; step(2);
      if (mode == 1) begin
         do_tick(5);
         start_stop = 1'b1; step(4);
         chk("early_press_state", st_a, 1);
         chk("early_press_run", run_a, 7);
         start_stop = 1'b0; step(3);
         do_tick(3);
      end else if (mode == 2) begin
         do_tick(7);
         start_stop = 1'b1; step(3);
         tick = 1'b1; step(1); tick = 1'b0;
         chk("tick_press_state", st_a, 1);
         start_stop = 1'b0; step(3);
      end else begin
         do_tick(8 + $urandom_range(0, 3));
      end
      start_stop = 1'b1; step(4);
      chk("stop1_state", st_a, 2);
      chk("stop1_run", run_a, 6);
      start_stop = 1'b0;
      do_tick(3);
      chk("stop1_hold", st_a, 2);
      do_tick(1);
      chk("stop2_state", st_a, 3);
      chk("stop2_run", run_a, 4);
      do_tick(3);
      chk("stop2_hold", run_a, 4);
      do_tick(1);
      chk("eval_state", st_a, 4);
      chk("eval_run", run_a, 0);
      step(1);
      if (w) begin
         exp_c = (exp_c + 5 > 255) ? 255 : exp_c + 5;
         chk("win_state", st_a, 5);
         chk("win_flag", wf_a, 1);
         chk("win_buzz", bz_a, 1);
         chk("win_credits", cr_a, exp_c);
         if (chk2) begin
            exp_c2 = (exp_c2 + 5 > 15) ? 15 : exp_c2 + 5;
            chk("win_credits_b", cr_b, exp_c2);
         end
         do_tick(15);
         chk("buzz_hold_state", st_a, 5);
         chk("buzz_hold", bz_a, 1);
         do_tick(1);
         chk("win_done_state", st_a, 0);
         chk("win_done_buzz", bz_a, 0);
         chk("win_flag_kept", wf_a, 1);
      end else begin
         chk("lose_state", st_a, 0);
         chk("lose_flag", wf_a, 0);
         chk("lose_buzz", bz_a, 0);
         chk("lose_credits", cr_a, exp_c);
         if (chk2) chk("lose_credits_b", cr_b, exp_c2);
      end
      step(2);
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; start_stop = 1'b0;
      sa = '0; sb = '0; sc = '0;
      exp_c = 10; exp_c2 = 13; chk2 = 1'b1;
      step(2);
      chk("rst_state", st_a, 0);
      chk("rst_run", run_a, 0);
      chk("rst_credits", cr_a, 10);
      chk("rst_credits_b", cr_b, 13);
      chk("rst_flag", wf_a, 0);
      rst = 1'b0;
      step(5);

      play_round(3, 3, 3, 0);
      play_round(1, 2, 1, 1);
      play_round($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 2);
      for (int i = 0; i < 6; i++)
         play_round($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 2));

      // Drain to zero; the narrow instance falls out of lockstep here.
      chk2 = 1'b0;
      for (int i = 0; i < 200 && exp_c > 0; i++) play_round(1, 2, 3, 0);
      chk("drained", cr_a, 0);
      start_stop = 1'b1; step(4);
      chk("zero_press_state", st_a, 0);
      chk("zero_press_clear", clr_a, 0);
      step(1);
      chk("zero_press_clear2", clr_a, 0);
      start_stop = 1'b0; step(3);

      // Fresh reset, then abandon a round in STOP2.
      rst = 1'b1; step(1); rst = 1'b0; step(4);
      exp_c = 10; exp_c2 = 13; chk2 = 1'b1;
      chk("rst2_credits", cr_a, 10);
      start_stop = 1'b1; step(4);
      chk("abort_spin", st_a, 1);
      start_stop = 1'b0; step(2);
      do_tick(8);
      start_stop = 1'b1; step(4); start_stop = 1'b0;
      do_tick(4);
      chk("abort_in_stop2", st_a, 3);
      start_stop = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("abort_run", run_a, 0);
      chk("abort_state", st_a, 0);
      chk("abort_credits", cr_a, 10);
      chk("abort_credits_b", cr_b, 13);
      step(2);
      rst = 1'b0;
      step(10);
      chk("held_press_state", st_a, 0);
      chk("held_press_clear", clr_a, 0);
      start_stop = 1'b0; step(4);
      play_round(5, 5, 5, 0);
      play_round($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/slot_round_controller.md
# slot_round_controller

Sequences one play round of the three-reel slot machine. Debounced start_stop presses start all reels together and then stop them one at a time, with a fixed gap between stops. It compares the three stopped symbols, keeps a saturating credit balance, and times the win buzzer. It sits between the button input and the three slot modules, and replaces the free-running start/stop FSM as the owner of reel enables.

## Interface
Parameters:
- SYM_W, 4, width of one reel symbol
- CREDIT_W, 8, credit counter width
- INIT_CREDITS, 10, credit value loaded at reset
- PAYOUT, 5, credits added on a win
- MIN_SPIN_TICKS, 8, ticks all reels must spin before a stop press is accepted
- STAGGER_TICKS, 4, ticks between successive reel stops
- WIN_TICKS, 16, ticks the buzzer stays enabled after a win

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset; asynchronous and active-high
- tick  in  1  one-clk-wide timebase pulse (slow-clock enable)
- start_stop  in  1  raw player button, asynchronous to clk
- reel0_sym, reel1_sym, reel2_sym  in  SYM_W each  current symbol of each reel
- reel_run  out  3  bit i=1 lets reel i advance
- reel_clear  out  1  one-clk pulse; reels reload their start symbol
- win_flag  out  1  result of the last evaluated round
- buzzer_en  out  1  high during the win display
- credits  out  CREDIT_W  current balance
- state_o  out  3  encoded FSM state, for display and debug

## Operation
- Input path: start_stop passes through a 2-flop synchronizer, then a rising-edge detect. The result is `press`, one clk wide.
- States and encodings: IDLE=0, SPIN=1, STOP1=2, STOP2=3, EVAL=4, WIN=5.
- A single tick counter `tcnt` is cleared on every state entry. It increments on tick and saturates at its maximum.
- IDLE:
  - reel_run=000.
  - press with credits≠0 → SPIN. In that same transition: credits−1, reel_clear=1 for one clk, win_flag cleared.
  - press with credits=0 is ignored.
- SPIN:
  - reel_run=111.
  - press with tcnt≥MIN_SPIN_TICKS → STOP1.
  - An earlier press is discarded; it is not queued.
- STOP1:
  - reel_run=110.
  - tcnt reaches STAGGER_TICKS → STOP2.
- STOP2:
  - reel_run=100.
  - tcnt reaches STAGGER_TICKS → EVAL.
- EVAL (one clk):
  - reel_run=000.
  - win = reel0_sym==reel1_sym && reel1_sym==reel2_sym.
  - win → WIN. win_flag is set to 1 and credits += PAYOUT, saturating at 2^CREDIT_W−1.
  - No win → IDLE, with win_flag set to 0.
- WIN:
  - reel_run=000, buzzer_en=1.
  - tcnt reaches WIN_TICKS → IDLE.
- press is ignored in STOP1, STOP2, EVAL and WIN.
- Decrement never underflows, because entry to SPIN requires credits≠0.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE; reel_run=000, reel_clear=0, buzzer_en=0, win_flag=0.
  - credits=INIT_CREDITS, tcnt=0, synchronizer flops=0.
- All outputs are registered.
- press asserts 3 clks after start_stop rises, once it has been stable for 2 clks.
- IDLE→SPIN:
  - The state, reel_run, reel_clear and the credit decrement all become visible on the clk edge after press.
  - reel_clear is high for exactly that one cycle.
- Stop ordering:
  - reel0 stops 1 clk after an accepted press.
  - reel1 stops on the clk after the STAGGER_TICKS-th tick in STOP1.
  - reel2 stops on the clk after the STAGGER_TICKS-th tick in STOP2.
- Evaluation:
  - EVAL lasts exactly 1 clk.
  - reel symbols are sampled in EVAL.
  - win_flag and credits update on the clk leaving EVAL.
- press and tick in the same clk: tick increments tcnt; press is judged against the pre-increment tcnt.
- Reset mid-round: the round is abandoned with no credit refund; all outputs return to their reset values at once.

## Test plan
- Reset, then press with reel symbols 3,3,3 → credits 10→9 on SPIN entry. Stops occur in order 110, 100, 000 at 4-tick spacing. win_flag=1, credits=14, buzzer_en high for 16 ticks, then IDLE.
- Symbols 1,2,1 at EVAL → win_flag=0, credits stays 9, buzzer_en never asserts, state returns to 0.
- Press at tcnt=5 in SPIN → ignored, reel_run stays 111. Press at tcnt=8 → STOP1 next clk.
- Force credits to 0 by playing 10 losing rounds, then press → remains IDLE, reel_clear stays 0. With CREDIT_W=4 and credits=13, a win → credits=15 (saturated).
- Assert rst in STOP2 → reel_run=000, state_o=0, credits=10 immediately. A press held across reset release does not start a round until the button is released and pressed again.
- press coincident with tick at tcnt=7 in SPIN → rejected. The next press at tcnt=8 is accepted.
